// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    // Byte-select width for a given data width.
    function automatic int WB_SEL_W(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/wb_sdram_arbiter.sv
// Two-master round-robin pipelined Wishbone arbiter in front of the sdram slave port.
// Latency: 1 cycle from cyc to grant; request/stall/ack/data paths 0 cycles while owned.
// Backpressure: owner sees slave stall or a full outstanding counter; a non-owner is always stalled.
module wb_sdram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [WB_SEL_W(DW)-1:0] m0_sel_i,
    input  logic [AW-1:0]           m0_addr_i,
    input  logic [DW-1:0]           m0_data_i,
    output logic [DW-1:0]           m0_data_o,
    output logic                    m0_stall_o,
    output logic                    m0_ack_o,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [WB_SEL_W(DW)-1:0] m1_sel_i,
    input  logic [AW-1:0]           m1_addr_i,
    input  logic [DW-1:0]           m1_data_i,
    output logic [DW-1:0]           m1_data_o,
    output logic                    m1_stall_o,
    output logic                    m1_ack_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [WB_SEL_W(DW)-1:0] s_sel_o,
    output logic [AW-1:0]           s_addr_o,
    output logic [DW-1:0]           s_data_o,
    input  logic [DW-1:0]           s_data_i,
    input  logic                    s_stall_i,
    input  logic                    s_ack_i,
    output logic [1:0]              grant_o,
    output logic                    proto_err_o
);

    localparam int            CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          proto_err_q, proto_err_d;

    logic own0, own1, own_cyc, cnt_full, cnt_zero, accept, ack_ok;

    assign own0     = (state_q == ST_OWN0);
    assign own1     = (state_q == ST_OWN1);
    assign own_cyc  = own1 ? m1_cyc_i : m0_cyc_i;
    assign cnt_full = (cnt_q == MAX_CNT);
    assign cnt_zero = (cnt_q == '0);
    assign accept   = s_stb_o & ~s_stall_i;
    // An ack with nothing outstanding is a slave error, never a completion.
    assign ack_ok   = s_ack_i & ~cnt_zero;

    assign m0_ack_o    = own0 & ack_ok;
    assign m1_ack_o    = own1 & ack_ok;
    assign m0_stall_o  = ~own0 | s_stall_i | cnt_full;
    assign m1_stall_o  = ~own1 | s_stall_i | cnt_full;
    assign m0_data_o   = s_data_i;
    assign m1_data_o   = s_data_i;
    assign grant_o     = {own1, own0};
    assign proto_err_o = proto_err_q;

    // Forward the owner's request to the slave; DRAIN keeps the cycle open with no new strobes.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        if (own0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_cyc_i & m0_stb_i & ~cnt_full;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
        end else if (own1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_cyc_i & m1_stb_i & ~cnt_full;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
        end else if (state_q == ST_DRAIN) begin
            s_cyc_o  = 1'b1;
        end
    end

    // Outstanding counter, sticky error and the arbitration / release decisions.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !ack_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && ack_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
        proto_err_d = proto_err_q | (s_ack_i & cnt_zero);
        state_d     = state_q;
        last_d      = last_q;
        case (state_q)
            ST_IDLE: begin
                // On a tie, master 0 wins only if master 1 was granted last.
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = ST_OWN0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = ST_OWN1;
                    last_d  = 1'b1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                // An abandoned cycle with acks in flight must be drained before anyone else owns the slave.
                if (!own_cyc) begin
                    state_d = (cnt_d == '0) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_d == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset idles the slave immediately and lets master 0 win the first tie.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter: directed scenarios plus randomized two-master traffic.
// Latency: checks every cycle at the falling edge against a transaction-level ownership model.
// Backpressure: bench slave drives random stall and held/delayed acks.
`timescale 1ns/1ps
module tb_wb_sdram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]    cyc = '0;
    logic [1:0]    stb = '0;
    logic [1:0]    we  = '0;
    logic [SW-1:0] sel  [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdat [2];
    wire  [DW-1:0] rdat0, rdat1;
    wire  [1:0]    stall, ack;
    wire           s_cyc, s_stb, s_we;
    wire  [SW-1:0] s_sel;
    wire  [AW-1:0] s_addr;
    wire  [DW-1:0] s_wdat;
    logic [DW-1:0] s_rdat  = '0;
    logic          s_stall = 1'b0;
    logic          s_ack   = 1'b0;
    wire  [1:0]    grant;
    wire           perr;

    wb_sdram_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
        .m0_addr_i(addr[0]), .m0_data_i(wdat[0]), .m0_data_o(rdat0),
        .m0_stall_o(stall[0]), .m0_ack_o(ack[0]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
        .m1_addr_i(addr[1]), .m1_data_i(wdat[1]), .m1_data_o(rdat1),
        .m1_stall_o(stall[1]), .m1_ack_o(ack[1]),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_addr_o(s_addr), .s_data_o(s_wdat), .s_data_i(s_rdat),
        .s_stall_i(s_stall), .s_ack_i(s_ack),
        .grant_o(grant), .proto_err_o(perr)
    );

    int checks = 0;
    int passes = 0;
    int fails_shown = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else begin
            if (fails_shown < 40)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
            fails_shown++;
        end
    endtask

    int unsigned cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Bench slave: acks each accepted request ack_lat cycles later unless acks are held.
    int unsigned ack_due[$];
    bit hold_acks = 0, spur = 0, ack_seen = 0;
    int ack_lat = 2, stall_pct = 0, stb_pre_ack = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (s_ack) ack_seen = 1;
            if (!rst_n) ack_due.delete();
            else if (s_stb && !s_stall) begin
                ack_due.push_back(cyc_n + ack_lat);
                if (!ack_seen) stb_pre_ack++;
            end
            @(posedge clk); #1;
            s_rdat  = $urandom;
            s_stall = ($urandom_range(99) < stall_pct);
            s_ack   = 1'b0;
            if (spur) begin
                s_ack = 1'b1;
                spur  = 0;
            end else if (!hold_acks && ack_due.size() > 0 && ack_due[0] <= cyc_n) begin
                s_ack = 1'b1;
                void'(ack_due.pop_front());
            end
        end
    end

    // Reference model: owner (-1 none, 0/1 master, 2 draining), outstanding count, last winner, sticky error.
    int m_own = -1, m_out = 0, m_last = 1, m_peak = 0;
    bit m_err = 0;
    logic [1:0] glog[$];
    always @(negedge clk) begin
        logic es_cyc, es_stb, es_we;
        logic [SW-1:0] es_sel;
        logic [AW-1:0] es_addr;
        logic [DW-1:0] es_dat;
        logic [1:0] est, eack, eg;
        int m, acc, ak, pick;
        es_cyc = 0; es_stb = 0; es_we = 0; es_sel = '0; es_addr = '0; es_dat = '0;
        est = 2'b11; eack = 2'b00; eg = 2'b00;
        if (!rst_n) begin
            m_own = -1; m_out = 0; m_last = 1; m_err = 0;
            chk("reset_outputs", {s_cyc, s_stb, s_we, s_sel, s_addr, s_wdat, grant, stall, ack, perr}, 79'(12'b000_0000_11_00_0) << 0 | 79'h0 | {71'h0, 8'b00_11_00_0});
            chk("reset_rdata", {rdat0, rdat1}, {s_rdat, s_rdat});
        end else begin
            if (m_own == 0 || m_own == 1) begin
                m = m_own;
                es_cyc = cyc[m];
                es_stb = cyc[m] & stb[m] & (m_out < MAX_OUT);
                es_we = we[m]; es_sel = sel[m]; es_addr = addr[m]; es_dat = wdat[m];
                est[m] = s_stall | (m_out == MAX_OUT);
                eack[m] = s_ack && (m_out > 0);
                eg[m] = 1'b1;
            end else if (m_own == 2) begin
                es_cyc = 1'b1;
            end
            chk("slave_bus", {s_cyc, s_stb, s_we, s_sel, s_addr, s_wdat},
                {es_cyc, es_stb, es_we, es_sel, es_addr, es_dat});
            chk("m0_resp", {stall[0], ack[0], rdat0}, {est[0], eack[0], s_rdat});
            chk("m1_resp", {stall[1], ack[1], rdat1}, {est[1], eack[1], s_rdat});
            chk("grant", grant, eg);
            chk("proto_err", perr, m_err);
            acc = (es_stb && !s_stall) ? 1 : 0;
            ak  = (s_ack && m_out > 0) ? 1 : 0;
            if (s_ack && m_out == 0) m_err = 1;
            m_out = m_out + acc - ak;
            if (m_out > m_peak) m_peak = m_out;
            if (m_own < 0) begin
                pick = -1;
                if (cyc[0] && cyc[1]) pick = 1 - m_last;
                else if (cyc[0]) pick = 0;
                else if (cyc[1]) pick = 1;
                if (pick >= 0) begin m_own = pick; m_last = pick; end
            end else if (m_own < 2) begin
                if (!cyc[m_own]) m_own = (m_out == 0) ? -1 : 2;
            end else if (m_out == 0) begin
                m_own = -1;
            end
            glog.push_back(grant);
        end
    end

    task automatic drive_req(input int m, input int idx, input logic [31:0] base, input int wmode);
        addr[m] = (base != 0) ? base + 32'(4 * idx) : ($urandom & 32'hFFFF_FFFC);
        wdat[m] = $urandom;
        sel[m]  = SW'($urandom);
        we[m]   = (wmode == 2) ? 1'($urandom) : (wmode == 1);
    endtask

    // Pipelined master: issues n requests, then drops cyc after all acks (or at once when aborting).
    task automatic master(input int m, input int n, input bit abort, input logic [31:0] base,
                          input int wmode, output int acks, output int start_c);
        int issued = 0;
        bit acc;
        bit done = 0;
        acks = 0;
        @(posedge clk); #1;
        start_c = int'(cyc_n);
        cyc[m] = 1'b1; stb[m] = 1'b1;
        drive_req(m, 0, base, wmode);
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (!rst_n) begin
                @(posedge clk); #1;
                cyc[m] = 1'b0; stb[m] = 1'b0; done = 1;
            end else begin
                acc = stb[m] && !stall[m];
                if (acc) issued++;
                if (ack[m]) acks++;
                @(posedge clk); #1;
                if (issued == n) stb[m] = 1'b0;
                else if (acc) drive_req(m, issued, base, wmode);
                if (issued == n && (abort || acks == n)) begin
                    cyc[m] = 1'b0; stb[m] = 1'b0; done = 1;
                end
            end
        end
        chk("master_done", done, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
    endtask

    int ra0, ra1, ra2, sc0, sc1, sc2, gcyc, nsack;
    bit found;
    int runs[$];
    int gaps[$];

    initial begin
        for (int i = 0; i < 2; i++) begin sel[i] = '0; addr[i] = '0; wdat[i] = '0; end
        @(posedge clk); #2;
        chk("rst_literal", {s_cyc, s_stb, grant, stall, ack, perr}, 9'b0_0_00_11_00_0);
        @(posedge clk); #3 rst_n = 1'b1;

        // Single master: three writes from 0x100, 2-cycle ack latency.
        ack_lat = 2; stall_pct = 0; m_peak = 0; gcyc = 0;
        fork
            master(0, 3, 0, 32'h100, 1, ra0, sc0);
            begin
                found = 0;
                for (int i = 0; i < 20 && !found; i++) begin
                    @(negedge clk);
                    if (grant == 2'b01) begin found = 1; gcyc = int'(cyc_n); end
                end
            end
        join
        chk("s1_grant_latency", gcyc - sc0, 1);
        chk("s1_acks", ra0, 3);
        chk("s1_peak_outstanding", m_peak, 2);
        repeat (2) @(negedge clk);
        chk("s1_idle", {grant, s_cyc}, 3'b000);

        // Ties: m0 wins after reset; m0 re-requests in the dead cycle and m1 wins that tie.
        do_reset();
        glog.delete();
        fork
            begin
                master(0, 1, 0, 0, 2, ra0, sc0);
                master(0, 1, 0, 0, 2, ra2, sc2);
            end
            master(1, 2, 0, 0, 2, ra1, sc1);
        join
        runs.delete(); gaps.delete();
        begin
            logic [1:0] prev;
            int z;
            prev = 2'b00; z = 0;
            foreach (glog[i]) begin
                if (glog[i] == 2'b00) z++;
                else begin
                    if (glog[i] != prev) begin runs.push_back(int'(glog[i])); gaps.push_back(z); end
                    z = 0;
                end
                prev = glog[i];
            end
        end
        chk("tie_run_count", runs.size(), 3);
        if (runs.size() >= 3) begin
            chk("tie_first_m0", runs[0], 1);
            chk("tie_second_m1", runs[1], 2);
            chk("tie_dead_cycle", gaps[1], 1);
            chk("tie_third_m0", runs[2], 1);
        end
        chk("tie_acks", {ra0[7:0], ra1[7:0], ra2[7:0]}, 24'h01_02_01);

        // Backpressure: acks held, 6 reads, only MAX_OUT accepted before the first ack.
        hold_acks = 1; ack_lat = 1; stb_pre_ack = 0; ack_seen = 0;
        fork
            master(0, 6, 0, 0, 0, ra0, sc0);
            begin
                repeat (12) @(negedge clk);
                chk("bp_stalled", {stall[0], s_stb}, 2'b10);
                hold_acks = 0;
            end
        join
        chk("bp_pre_ack_requests", stb_pre_ack, 4);
        chk("bp_acks", ra0, 6);

        // Abort with two acks pending: drained and swallowed.
        ack_lat = 3;
        master(0, 2, 1, 0, 2, ra0, sc0);
        @(negedge clk);
        chk("abort_own_cyc_low", {grant, s_cyc}, 3'b010);
        nsack = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_drain", {grant, s_cyc, s_stb, ack[0]}, 5'b00100);
            if (s_ack) nsack++;
        end
        chk("abort_swallowed", nsack, 2);
        @(negedge clk);
        chk("abort_idle", {grant, s_cyc}, 3'b000);

        // Spurious ack in IDLE.
        spur = 1; found = 0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            if (s_ack) begin found = 1; chk("spur_no_master_ack", ack, 2'b00); end
        end
        chk("spur_seen", found, 1'b1);
        @(negedge clk);
        chk("spur_err", perr, 1'b1);
        repeat (4) @(negedge clk);
        chk("spur_sticky", {perr, grant}, 3'b100);

        // Asynchronous reset while m1 owns with three outstanding.
        hold_acks = 1; ack_lat = 1;
        fork
            master(1, 3, 0, 0, 2, ra1, sc1);
            begin
                found = 0;
                for (int i = 0; i < 40 && !found; i++) begin
                    @(negedge clk); #1;
                    if (m_out == 3) found = 1;
                end
                chk("arst_reached_cnt3", found, 1'b1);
                @(posedge clk); #1;
                chk("arst_own1", grant, 2'b10);
                #1 rst_n = 1'b0;
                #1;
                chk("arst_outputs", {s_cyc, s_stb, grant, stall, ack, perr}, 9'b0_0_00_11_00_0);
                @(posedge clk); #3 rst_n = 1'b1;
                hold_acks = 0;
            end
        join
        ack_lat = 2;
        master(0, 2, 0, 0, 1, ra0, sc0);
        chk("post_rst_acks", ra0, 2);

        // Randomized contention.
        for (int it = 0; it < 40; it++) begin
            ack_lat = $urandom_range(1, 4);
            stall_pct = $urandom_range(0, 40);
            fork
                begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    master(0, $urandom_range(1, 6), ($urandom_range(3) == 0), 0, 2, ra0, sc0);
                end
                begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    master(1, $urandom_range(1, 6), ($urandom_range(3) == 0), 0, 2, ra1, sc1);
                end
            join
        end
        stall_pct = 0;
        repeat (12) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, %0d checks so far", checks);
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_sdram_arbiter.md
# wb_sdram_arbiter

Two-master round-robin arbiter for pipelined Wishbone, placed in front of the `sdram` controller's slave port so that the UART bridge (master 0) and a video/DMA fetch path (master 1) can share the external RAM. It grants the bus to one master per Wishbone cycle and counts outstanding requests so every `ack` reaches the master that issued it. When a master aborts a cycle, the arbiter drains that master's outstanding acks before it re-arbitrates.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width; select width is `DW/8`
- `MAX_OUT`, 4, maximum accepted-but-unacked requests; counter width `$clog2(MAX_OUT+1)`

Ports:
- `clk_i`  in  1  single clock, all logic rising-edge
- `rst_n_i`  in  1  reset, asynchronous assert, active-low
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 Wishbone controls
- `m0_sel_i`  in  DW/8;  `m0_addr_i`  in  AW;  `m0_data_i`  in  DW
- `m0_data_o`  out  DW;  `m0_stall_o`, `m0_ack_o`  out  1
- `m1_*`: same set as `m0_*`, for master 1
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1;  `s_sel_o`  out  DW/8;  `s_addr_o`  out  AW;  `s_data_o`  out  DW  (to the sdram slave)
- `s_data_i`  in  DW;  `s_stall_i`, `s_ack_i`  in  1
- `grant_o`  out  2  one-hot current owner, 00 when idle
- `proto_err_o`  out  1  sticky: `s_ack_i` arrived while the outstanding count was 0

## Operation
- States: IDLE, OWN0, OWN1, DRAIN. A register `last` holds the index of the most recently granted master.
- IDLE: if only one `mX_cyc_i` is high, go to OWNX. If both are high, grant the master other than `last`. Update `last` on every grant.
- OWNX forwarding: `s_cyc_o` = `mX_cyc_i`. `s_stb_o` = `mX_stb_i & (cnt < MAX_OUT)`. Address, data, sel and we pass through combinationally. `mX_stall_o` = `s_stall_i | (cnt == MAX_OUT)`.
- Accept: `s_stb_o & ~s_stall_i` increments `cnt`. `s_ack_i` decrements it. Both in the same cycle leave `cnt` unchanged.
- Ack routing: `mX_ack_o` = `s_ack_i` only in OWNX. `s_data_i` is broadcast to both `mX_data_o`.
- Leaving OWNX:
  - `mX_cyc_i` low and `cnt == 0`, or `cnt == 1` with `s_ack_i`: go to IDLE.
  - `mX_cyc_i` low with acks still pending: go to DRAIN.
- DRAIN: `s_cyc_o` = 1, `s_stb_o` = 0, acks are consumed and not forwarded. Exit to IDLE when `cnt` reaches 0.
- A master without grant sees `stall_o` = 1 and `ack_o` = 0. Its `cyc` is remembered only through the live input; nothing is queued.
- `s_ack_i` with `cnt == 0`: ignored, `cnt` stays 0, `proto_err_o` is set.

## Timing
- Reset values: state IDLE, `cnt` 0, `last` 1 (so master 0 wins the first tie), `grant_o` 00, `proto_err_o` 0.
  - All `s_*` outputs 0; all `mX_ack_o` 0; all `mX_stall_o` 1.
- Grant latency: `cyc` rising in cycle N gives ownership from cycle N+1. A master's first `stb` can be accepted at N+1 at the earliest.
- In OWN, request, stall, ack and data paths are combinational, adding 0 cycles beyond the slave.
- Release: the cycle after the exit condition, the state is IDLE. A pending request from the other master is granted one cycle later, so there is 1 dead cycle between owners.
- Reset asserted mid-transfer clears everything immediately. `s_cyc_o` drops asynchronously; the slave is expected to abandon the cycle.

## Structure
- Shared package `wb_arb_pkg`: state enum (IDLE/OWN0/OWN1/DRAIN) and a `WB_SEL_W(DW)` helper constant.
- No sub-module. An optional `wb_mux2` combinational forwarding mux is allowed; state, counter and arbitration stay in this module.

## Test plan
- Single master: m0 issues 3 pipelined writes to 0x100, 0x104, 0x108 with a stall-free slave and acks at 2-cycle latency.
  - Expect `grant_o` = 01 one cycle after `cyc`, `cnt` peaking at 2, 3 acks on `m0_ack_o`, and IDLE after `cyc` falls.
- Tie: m0 and m1 raise `cyc` in the same cycle after reset.
  - Expect m0 granted first and m1 granted 1 dead cycle after m0 releases.
  - On a second tie, expect m1 granted first.
- Backpressure: slave acks are held off, m0 requests 6 reads with `MAX_OUT` = 4.
  - Expect `m0_stall_o` high once `cnt` = 4, and exactly 4 requests on `s_stb_o` before the first ack.
- Abort: m0 drops `cyc` with 2 acks pending.
  - Expect DRAIN, `s_cyc_o` held high, 2 acks swallowed (`m0_ack_o` stays 0), then IDLE.
- Spurious ack: `s_ack_i` pulses in IDLE.
  - Expect `proto_err_o` = 1 and sticky, `cnt` = 0, and no master ack.
- Async reset pulse during OWN1 with `cnt` = 3.
  - Expect outputs at their reset values within the same cycle, and normal arbitration after release.
